// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS R-type sequencer and datapath:
// sequencer state encoding, instruction field positions, default R-type
// opcode and the funct codes understood by the ALU.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_RESPOND   = 3'd4
  } seq_state_e;

  // Instruction field positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  localparam logic [5:0] OPCODE_RTYPE_DEFAULT = 6'b000000;

  // Funct codes shared with the ALU
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;

endpackage

// File: rtl/mips_instr_decode.sv
// Combinational field split of a 32-bit MIPS instruction word.
module mips_instr_decode
  import mips_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [5:0]  o_opcode,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_shamt,
  output logic [5:0]  o_funct
);

  assign o_opcode = i_instr[OPCODE_MSB:OPCODE_LSB];
  assign o_rs     = i_instr[RS_MSB:RS_LSB];
  assign o_rt     = i_instr[RT_MSB:RT_LSB];
  assign o_rd     = i_instr[RD_MSB:RD_LSB];
  assign o_shamt  = i_instr[SHAMT_MSB:SHAMT_LSB];
  assign o_funct  = i_instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: rtl/mips_rtype_sequencer.sv
// Multi-cycle R-type sequencer: IDLE -> DECODE -> EXECUTE -> WRITEBACK ->
// RESPOND, one instruction at a time. Register-file read, ALU execute and
// writeback each get their own cycle; the result is returned over a
// valid/ready handshake.
// Optional: define MIPS_SEQ_STATS_EN to add the retired_count port/counter.
module mips_rtype_sequencer
  import mips_pkg::*;
#(
  parameter logic [5:0] OPCODE_RTYPE = OPCODE_RTYPE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [4:0]  rf_read_reg_1,
  output logic [4:0]  rf_read_reg_2,
  input  logic [31:0] rf_read_data_1,
  input  logic [31:0] rf_read_data_2,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  output logic        rf_write_en,
  output logic [5:0]  alu_opcode,
  output logic [5:0]  alu_funct,
  output logic [4:0]  alu_shamt,
  output logic [31:0] alu_inp1,
  output logic [31:0] alu_inp2,
  input  logic [31:0] alu_out,
  output logic [31:0] result,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy
`ifdef MIPS_SEQ_STATS_EN
  ,
  output logic [31:0] retired_count
`endif
);

  seq_state_e  r_state, w_next;
  logic [31:0] r_ir, r_op1, r_op2, r_result;
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;

  mips_instr_decode u_dec (
    .i_instr  (r_ir),
    .o_opcode (w_opcode),
    .o_rs     (w_rs),
    .o_rt     (w_rt),
    .o_rd     (w_rd),
    .o_shamt  (w_shamt),
    .o_funct  (w_funct)
  );

  // Address/operand outputs follow the latched registers so they stay
  // stable outside the state that uses them.
  assign rf_read_reg_1 = w_rs;
  assign rf_read_reg_2 = w_rt;
  assign rf_write_reg  = w_rd;
  assign rf_write_data = r_result;
  assign alu_opcode    = w_opcode;
  assign alu_funct     = w_funct;
  assign alu_shamt     = w_shamt;
  assign alu_inp1      = r_op1;
  assign alu_inp2      = r_op2;
  assign result        = r_result;

  // State register; reset aborts any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and state-decoded outputs. The write strobe is a pure
  // function of state, so an asynchronous reset kills it immediately.
  always_comb begin
    w_next       = r_state;
    instr_ready  = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    rf_write_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) w_next = ST_DECODE;
      end
      ST_DECODE:    w_next = ST_EXECUTE;
      ST_EXECUTE:   w_next = ST_WRITEBACK;
      ST_WRITEBACK: begin
        // Writes to $zero and from non-R-type opcodes are suppressed
        rf_write_en = (w_opcode == OPCODE_RTYPE) && (w_rd != 5'd0);
        w_next      = ST_RESPOND;
      end
      ST_RESPOND: begin
        result_valid = 1'b1;
        if (result_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath capture: instruction on accept, operands in DECODE,
  // ALU result in EXECUTE (held through WRITEBACK and RESPOND)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir     <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE:    if (instr_valid) r_ir <= instr;
        ST_DECODE: begin
          r_op1 <= rf_read_data_1;
          r_op2 <= rf_read_data_2;
        end
        ST_EXECUTE: r_result <= alu_out;
        default: ;
      endcase
    end
  end

`ifdef MIPS_SEQ_STATS_EN
  logic [31:0] r_retired;

  // Count retirements on RESPOND -> IDLE; wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_retired <= '0;
    else if (r_state == ST_RESPOND && result_ready) r_retired <= r_retired + 32'd1;
  end

  assign retired_count = r_retired;
`else
  // Statistics counter not built
`endif

endmodule

// File: tb/tb_mips_rtype_sequencer.sv
// Directed bench for mips_rtype_sequencer with a small register-file and
// ALU model. Define MIPS_SEQ_STATS_EN to also check retired_count.
module tb_mips_rtype_sequencer;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tb_init = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic [4:0]  rf_read_reg_1, rf_read_reg_2, rf_write_reg;
  logic [31:0] rf_read_data_1, rf_read_data_2, rf_write_data;
  logic        rf_write_en;
  logic [5:0]  alu_opcode, alu_funct;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_inp1, alu_inp2, alu_out, result;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        busy;
`ifdef MIPS_SEQ_STATS_EN
  logic [31:0] retired_count;
`endif

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  mips_rtype_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_ready    (instr_ready),
    .rf_read_reg_1  (rf_read_reg_1),
    .rf_read_reg_2  (rf_read_reg_2),
    .rf_read_data_1 (rf_read_data_1),
    .rf_read_data_2 (rf_read_data_2),
    .rf_write_reg   (rf_write_reg),
    .rf_write_data  (rf_write_data),
    .rf_write_en    (rf_write_en),
    .alu_opcode     (alu_opcode),
    .alu_funct      (alu_funct),
    .alu_shamt      (alu_shamt),
    .alu_inp1       (alu_inp1),
    .alu_inp2       (alu_inp2),
    .alu_out        (alu_out),
    .result         (result),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .busy           (busy)
`ifdef MIPS_SEQ_STATS_EN
    ,
    .retired_count  (retired_count)
`endif
  );

  // Register-file model: R1=5, R2=7, everything else 0 at start
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      rf[1] <= 32'd5;
      rf[2] <= 32'd7;
    end else if (rf_write_en && rf_write_reg != 5'd0) begin
      rf[rf_write_reg] <= rf_write_data;
    end
  end
  assign rf_read_data_1 = rf[rf_read_reg_1];
  assign rf_read_data_2 = rf[rf_read_reg_2];

  // ALU model
  always_comb begin
    alu_out = 32'hDEADBEEF;
    case (alu_funct)
      FUNCT_ADD: alu_out = alu_inp1 + alu_inp2;
      FUNCT_SUB: alu_out = alu_inp1 - alu_inp2;
      FUNCT_AND: alu_out = alu_inp1 & alu_inp2;
      FUNCT_OR:  alu_out = alu_inp1 | alu_inp2;
      default:   alu_out = 32'hDEADBEEF;
    endcase
  end

  // Count write-strobe cycles
  always @(negedge clk) if (rf_write_en === 1'b1) wr_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and return just after its accept edge
  task automatic issue(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    instr = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (instr_ready) ok = 1'b1;
      step();
    end
    instr_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL issue_timeout instr=%08h not accepted within 20 cycles", w); end
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (instr_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0 || rf_write_en !== 1'b0)
      begin errors++; $display("FAIL reset_in ready=%b busy=%b rv=%b we=%b want 1 0 0 0", instr_ready, busy, result_valid, rf_write_en); end
    tb_init = 1'b0;
    rst_n = 1'b1;
    step();
    checks++; if (instr_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0 || rf_write_en !== 1'b0)
      begin errors++; $display("FAIL reset_idle ready=%b busy=%b rv=%b we=%b want 1 0 0 0", instr_ready, busy, result_valid, rf_write_en); end
    checks++; if (result !== 32'd0 || alu_inp1 !== 32'd0 || rf_write_reg !== 5'd0)
      begin errors++; $display("FAIL reset_regs result=%h inp1=%h wreg=%0d want 0", result, alu_inp1, rf_write_reg); end
`ifdef MIPS_SEQ_STATS_EN
    checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL reset_retired got=%0d want=0", retired_count); end
`endif
  endtask

  // add $3,$1,$2
  task automatic test_add();
    wr_cnt = 0;
    issue(32'h00221820);
    checks++; if (busy !== 1'b1 || instr_ready !== 1'b0)
      begin errors++; $display("FAIL add_decode busy=%b ready=%b want 1 0", busy, instr_ready); end
    step(); // EXECUTE
    checks++; if (alu_inp1 !== 32'd5 || alu_inp2 !== 32'd7 || alu_funct !== 6'h20 || rf_read_reg_1 !== 5'd1 || rf_read_reg_2 !== 5'd2)
      begin errors++; $display("FAIL add_exec inp1=%0d inp2=%0d funct=%h rs=%0d rt=%0d want 5 7 20 1 2", alu_inp1, alu_inp2, alu_funct, rf_read_reg_1, rf_read_reg_2); end
    checks++; if (result_valid !== 1'b0 || rf_write_en !== 1'b0)
      begin errors++; $display("FAIL add_exec_ctl rv=%b we=%b want 0 0", result_valid, rf_write_en); end
    step(); // WRITEBACK
    checks++; if (rf_write_en !== 1'b1 || rf_write_reg !== 5'd3 || rf_write_data !== 32'd12)
      begin errors++; $display("FAIL add_wb we=%b wreg=%0d wdata=%0d want 1 3 12", rf_write_en, rf_write_reg, rf_write_data); end
    step(); // RESPOND
    checks++; if (result_valid !== 1'b1 || result !== 32'd12 || rf_write_en !== 1'b0)
      begin errors++; $display("FAIL add_resp rv=%b result=%0d we=%b want 1 12 0", result_valid, result, rf_write_en); end
    checks++; if (wr_cnt !== 1 || rf[3] !== 32'd12)
      begin errors++; $display("FAIL add_write strobes=%0d r3=%0d want 1 12", wr_cnt, rf[3]); end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || instr_ready !== 1'b1)
      begin errors++; $display("FAIL add_ret busy=%b rv=%b ready=%b want 0 0 1", busy, result_valid, instr_ready); end
`ifdef MIPS_SEQ_STATS_EN
    checks++; if (retired_count !== 32'd1) begin errors++; $display("FAIL add_retired got=%0d want=1", retired_count); end
`endif
  endtask

  // add $0,$1,$2: result produced, write suppressed
  task automatic test_rd_zero();
    wr_cnt = 0;
    issue(32'h00220020);
    step(); step(); step();
    checks++; if (result_valid !== 1'b1 || result !== 32'd12)
      begin errors++; $display("FAIL rd0_resp rv=%b result=%0d want 1 12", result_valid, result); end
    checks++; if (wr_cnt !== 0 || rf[0] !== 32'd0)
      begin errors++; $display("FAIL rd0_nowrite strobes=%0d r0=%0d want 0 0", wr_cnt, rf[0]); end
    result_ready = 1'b1; step(); result_ready = 1'b0;
  endtask

  // lw-type opcode: response still given, no write
  task automatic test_non_rtype();
    wr_cnt = 0;
    issue(32'h8C000000);
    step();
    checks++; if (alu_opcode !== 6'h23) begin errors++; $display("FAIL nonr_opcode got=%h want=23", alu_opcode); end
    step(); step();
    checks++; if (result_valid !== 1'b1 || result !== 32'hDEADBEEF)
      begin errors++; $display("FAIL nonr_resp rv=%b result=%h want 1 deadbeef", result_valid, result); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL nonr_nowrite strobes=%0d want 0", wr_cnt); end
    result_ready = 1'b1; step(); result_ready = 1'b0;
  endtask

  // add $3,$1,$2 held in RESPOND for 10 cycles while sub $4,$3,$1 waits
  task automatic test_backpressure();
    bit bad_res, bad_rdy;
    issue(32'h00221820);
    instr = 32'h00612022;
    instr_valid = 1'b1;
    step(); step(); step();
    bad_res = 1'b0; bad_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (result !== 32'd12 || result_valid !== 1'b1) bad_res = 1'b1;
      if (instr_ready !== 1'b0) bad_rdy = 1'b1;
      step();
    end
    checks++; if (bad_res) begin errors++; $display("FAIL bp_hold result=%0d rv=%b want stable 12 1", result, result_valid); end
    checks++; if (bad_rdy) begin errors++; $display("FAIL bp_ready instr_ready rose during hold, want 0"); end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    checks++; if (instr_ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL bp_idle ready=%b busy=%b want 1 0", instr_ready, busy); end
    step();
    instr_valid = 1'b0;
    checks++; if (busy !== 1'b1 || instr_ready !== 1'b0)
      begin errors++; $display("FAIL bp_accept busy=%b ready=%b want 1 0", busy, instr_ready); end
    step(); step(); step();
    checks++; if (result_valid !== 1'b1 || result !== 32'd7 || rf[4] !== 32'd7)
      begin errors++; $display("FAIL bp_second rv=%b result=%0d r4=%0d want 1 7 7", result_valid, result, rf[4]); end
    result_ready = 1'b1; step(); result_ready = 1'b0;
  endtask

  // and $5,$3,$4 then add $7,$5,$1 reading the just-written $5
  task automatic test_back_to_back();
    result_ready = 1'b1;
    issue(32'h00642824);
    step(); step(); step();
    checks++; if (result_valid !== 1'b1 || result !== 32'd4)
      begin errors++; $display("FAIL b2b_first rv=%b result=%0d want 1 4", result_valid, result); end
    instr = 32'h00A13820;
    instr_valid = 1'b1;
    step();
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle ready=%b want 1", instr_ready); end
    step();
    instr_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b want 1", busy); end
    step(); step(); step();
    checks++; if (result_valid !== 1'b1 || result !== 32'd9)
      begin errors++; $display("FAIL b2b_second rv=%b result=%0d want 1 9", result_valid, result); end
    step();
    result_ready = 1'b0;
    checks++; if (rf[7] !== 32'd9 || busy !== 1'b0)
      begin errors++; $display("FAIL b2b_write r7=%0d busy=%b want 9 0", rf[7], busy); end
`ifdef MIPS_SEQ_STATS_EN
    checks++; if (retired_count !== 32'd7) begin errors++; $display("FAIL b2b_retired got=%0d want=7", retired_count); end
`endif
  endtask

  // add $6,$1,$2 aborted by reset during EXECUTE
  task automatic test_reset_mid();
    wr_cnt = 0;
    issue(32'h00223020);
    step(); // EXECUTE
    checks++; if (alu_inp1 !== 32'd5) begin errors++; $display("FAIL rmid_exec inp1=%0d want 5", alu_inp1); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (instr_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0 || rf_write_en !== 1'b0)
      begin errors++; $display("FAIL rmid_async ready=%b busy=%b rv=%b we=%b want 1 0 0 0", instr_ready, busy, result_valid, rf_write_en); end
    checks++; if (alu_inp1 !== 32'd0 || result !== 32'd0 || rf_write_reg !== 5'd0)
      begin errors++; $display("FAIL rmid_regs inp1=%0d result=%0d wreg=%0d want 0", alu_inp1, result, rf_write_reg); end
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (wr_cnt !== 0 || rf[6] !== 32'd0 || busy !== 1'b0)
      begin errors++; $display("FAIL rmid_nowrite strobes=%0d r6=%0d busy=%b want 0 0 0", wr_cnt, rf[6], busy); end
`ifdef MIPS_SEQ_STATS_EN
    checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL rmid_retired got=%0d want=0", retired_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_rd_zero();
    test_non_rtype();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_rtype_sequencer.md
# mips_rtype_sequencer

Multi-cycle controller that sequences the R-type datapath (register file plus ALU) one instruction at a time. It accepts 32-bit instructions over a valid/ready handshake and steps the register-file read, ALU execute and register-file writeback in fixed, separate cycles. It returns the ALU result over a second valid/ready handshake. It replaces the free-running write-enable/clock pulse in `mips_core` with a clean, reset-able, single-clock schedule.

## Interface
Parameters:
- `OPCODE_RTYPE`, default 6'b000000: opcode value that is allowed to write back.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  an instruction is offered.
- `instr`  in  32  instruction word. Fields: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct.
- `instr_ready`  out  1  the sequencer can accept an instruction.
- `rf_read_reg_1`, `rf_read_reg_2`  out  5  rs and rt read addresses.
- `rf_read_data_1`, `rf_read_data_2`  in  32  combinational register-file read data.
- `rf_write_reg`  out  5  rd write address.
- `rf_write_data`  out  32  writeback data.
- `rf_write_en`  out  1  one-cycle write strobe.
- `alu_opcode`  out  6  latched opcode.
- `alu_funct`  out  6  latched funct.
- `alu_shamt`  out  5  latched shamt.
- `alu_inp1`, `alu_inp2`  out  32  latched operands.
- `alu_out`  in  32  combinational ALU result.
- `result`  out  32  captured ALU result.
- `result_valid`  out  1  `result` is valid.
- `result_ready`  in  1  consumer accepts `result`.
- `busy`  out  1  high whenever state is not IDLE.
- `retired_count`  out  32  number of instructions retired; present only with `MIPS_SEQ_STATS_EN`.

## Operation
- States: IDLE, DECODE, EXECUTE, WRITEBACK, RESPOND.
- IDLE:
  - `instr_ready`=1.
  - If `instr_valid`, latch `instr` into the instruction register and go to DECODE.
- DECODE:
  - Drive `rf_read_reg_1`=rs and `rf_read_reg_2`=rt from the instruction register.
  - Capture `rf_read_data_1` and `rf_read_data_2` into the operand registers.
  - Go to EXECUTE.
- EXECUTE:
  - `alu_*` outputs are driven from the latched fields and operands.
  - Capture `alu_out` into the `result` register.
  - Go to WRITEBACK.
- WRITEBACK:
  - `rf_write_reg`=rd and `rf_write_data`=`result`.
  - `rf_write_en`=1 only if opcode==`OPCODE_RTYPE` and rd!=0. Writes to $zero are suppressed.
  - Go to RESPOND.
- RESPOND:
  - `result_valid`=1.
  - On `result_ready`, go to IDLE.
  - `result` holds its value until then.
- `rf_write_en` is 0 in every state except WRITEBACK.
- `rf_read_reg_*`, `rf_write_reg` and `alu_*` are continuously driven from the latched instruction and operand registers, so they stay stable outside their active states.
- Reset values:
  - State=IDLE.
  - All latched registers and `result` = 0.
  - `result_valid`=0, `rf_write_en`=0, `busy`=0, `instr_ready`=1.
  - `retired_count`=0.
- Reset asserted mid-operation aborts the instruction immediately. No write strobe may be issued after `rst_n` falls.

## Timing
- Accept edge = T0.
- DECODE occupies T0–T1, EXECUTE T1–T2, WRITEBACK T2–T3.
- `result_valid` rises after the T3 edge. Accept-to-result latency is 4 cycles.
- The register-file write lands on the edge that ends WRITEBACK.
- If `result_ready` is held high, the sequencer returns to IDLE one cycle after RESPOND is entered. Peak throughput is one instruction per 5 cycles.
- `instr_ready` is deasserted from T0 until IDLE is re-entered. An `instr_valid` held during this time is not consumed and is not lost.
- A back-to-back instruction reading the previous rd sees the written value, because the write completes before the next DECODE.

## Configuration
- `MIPS_SEQ_STATS_EN` defined:
  - 32-bit `retired_count` increments on each RESPOND→IDLE transition.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by reset.
- Not defined: the port and counter are absent, and all other behaviour is identical.

## Structure
- Package `mips_pkg` holds:
  - The state enum.
  - Field-position localparams (OPCODE_MSB, RS_LSB, …).
  - `OPCODE_RTYPE` default.
  - Funct constants shared with the ALU.
- A single flat module is sufficient.
- Optional sub-module `mips_instr_decode`: combinational field split of a 32-bit word, reusable by `mips_core`.

## Test plan
- Reset then idle:
  - Required: `instr_ready`=1, `result_valid`=0, `rf_write_en`=0, `busy`=0.
  - With `MIPS_SEQ_STATS_EN`: `retired_count`=0.
- ADD with R1=5, R2=7, instr 0x00221820 (add $3,$1,$2):
  - `rf_write_en` pulses exactly one cycle with `rf_write_reg`=3 and `rf_write_data`=12.
  - `result`=12 and `result_valid` rise 4 cycles after accept.
- Same ADD with rd=0 (0x00220020):
  - `result`=12, no `rf_write_en` pulse.
- Non-R-type opcode 0x8C000000:
  - `result_valid` is still asserted, no write strobe.
- Backpressure:
  - Hold `result_ready`=0 for 10 cycles with `instr_valid` held high on a second instruction.
  - Required: `result` is stable, `instr_ready`=0 throughout, and the second instruction is accepted exactly one cycle after `result_ready` rises.
- Reset mid-operation:
  - Drop `rst_n` during EXECUTE.
  - Required: no `rf_write_en` pulse, and outputs are at reset values immediately (asynchronous).
  - With stats enabled: `retired_count` is not incremented.
